// File: rtl/slave_link_receiver_pkg.sv
// Shared types and defaults for the board-to-board serial link receiver.
// Packet types, FSM state encoding and default frame/timeout sizes.
package slave_link_receiver_pkg;

   typedef enum logic [1:0] {
      PKT_ACK       = 2'b00,
      PKT_READY     = 2'b01,
      PKT_GAME_LOST = 2'b10,
      PKT_DATA      = 2'b11
   } pkt_type_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RECV  = 2'b01,
      ST_CHECK = 2'b10
   } link_rx_state_t;

   localparam int LINK_DATA_BITS      = 8;
   localparam int LINK_TIMEOUT_CYCLES = 2000;

   // Every parity-good packet except an ACK has to be acknowledged back to the master.
   function automatic logic needs_ack(input pkt_type_t t);
      return t != PKT_ACK;
   endfunction

endpackage

// File: rtl/slave_link_receiver_if.sv
// Serial pins from the master board plus the decoded-packet side seen by the sender FSM.
// The receiver uses the slave modport; whatever drives the pins uses the master modport.
interface slave_link_receiver_if
   import slave_link_receiver_pkg::*;
#(
   parameter int DATA_BITS = LINK_DATA_BITS
);

   logic                     serial_clk_in;
   logic                     serial_in_h;
   logic                     serial_in_0;
   logic                     serial_in_1;
   logic                     serial_in_2;
   logic                     serial_in_3;

   logic                     pkt_valid;
   pkt_type_t                pkt_type;
   logic                     pkt_seqNum;
   logic [4*DATA_BITS-1:0]   pkt_data;
   logic                     pkt_error;
   logic                     ack_req;
   logic                     ack_seqNum;
   logic [3:0]               packets_received_cnt;

   modport master (
      output serial_clk_in, serial_in_h, serial_in_0, serial_in_1, serial_in_2, serial_in_3,
      input  pkt_valid, pkt_type, pkt_seqNum, pkt_data, pkt_error,
      input  ack_req, ack_seqNum, packets_received_cnt
   );

   modport slave (
      input  serial_clk_in, serial_in_h, serial_in_0, serial_in_1, serial_in_2, serial_in_3,
      output pkt_valid, pkt_type, pkt_seqNum, pkt_data, pkt_error,
      output ack_req, ack_seqNum, packets_received_cnt
   );

endinterface

// File: rtl/slave_link_receiver_sync.sv
// Brings the asynchronous serial clock and the five lanes into the clk domain and
// produces a single-cycle sclk_rise strobe; also generates the sync-released local reset.
module slave_link_receiver_sync (
   input  logic       clk,
   input  logic       rst_l,
   input  logic       serial_clk_in,
   input  logic [4:0] lanes_async,
   output logic       rst_sync_l,
   output logic [4:0] lanes_sync,
   output logic       sclk_rise
);

   logic       rst_meta;
   logic [5:0] sync1;
   logic [5:0] sync2;
   logic       sclk_d3;

   // Reset asserts asynchronously and releases on a clk edge.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         rst_meta   <= 1'b0;
         rst_sync_l <= 1'b0;
      end else begin
         rst_meta   <= 1'b1;
         rst_sync_l <= rst_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_sync_l) begin
      if (!rst_sync_l) begin
         sync1   <= '0;
         sync2   <= '0;
         sclk_d3 <= 1'b0;
      end else begin
         sync1   <= {serial_clk_in, lanes_async};
         sync2   <= sync1;
         sclk_d3 <= sync2[5];
      end
   end

   assign lanes_sync = sync2[4:0];
   assign sclk_rise  = sync2[5] & ~sclk_d3;

endmodule

// File: rtl/slave_link_receiver.sv
// Slave-side receiver of the 5-lane board-to-board link: deserializes frames, checks parity,
// filters retransmitted DATA frames by sequence bit and raises packet / ACK-request pulses.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------------
//   ST_IDLE  | waiting for a serial-clock rise with the header lane high (start)
//   ST_RECV  | shifting DATA_BITS samples; timeout down-counter armed
//   ST_CHECK | one cycle while the decoded result pulses on the outputs
module slave_link_receiver
   import slave_link_receiver_pkg::*;
#(
   parameter int DATA_BITS      = LINK_DATA_BITS,
   parameter int TIMEOUT_CYCLES = LINK_TIMEOUT_CYCLES
) (
   input  logic                 clk,
   input  logic                 rst_l,
   slave_link_receiver_if.slave link
);

   localparam int BCW = $clog2(DATA_BITS);
   localparam int TCW = $clog2(TIMEOUT_CYCLES);
   localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);
   localparam logic [TCW-1:0] TMO_LOAD = TCW'(TIMEOUT_CYCLES - 1);

   logic       rst_sync_l;
   logic [4:0] lanes_sync;
   logic       sclk_rise;

   slave_link_receiver_sync u_sync (
      .clk           (clk),
      .rst_l         (rst_l),
      .serial_clk_in (link.serial_clk_in),
      .lanes_async   ({link.serial_in_h, link.serial_in_3, link.serial_in_2,
                       link.serial_in_1, link.serial_in_0}),
      .rst_sync_l    (rst_sync_l),
      .lanes_sync    (lanes_sync),
      .sclk_rise     (sclk_rise)
   );

   link_rx_state_t            state, state_next;
   logic [BCW-1:0]            bit_cnt, bit_cnt_next;
   logic [TCW-1:0]            tmo_cnt, tmo_cnt_next;
   logic [DATA_BITS-1:0]      hdr_sr, hdr_sr_next, hdr_shift;
   logic [3:0][DATA_BITS-1:0] lane_sr, lane_sr_next, lane_shift;

   pkt_type_t                 frame_type;
   logic                      frame_seq;
   logic                      parity_ok;
   logic                      is_dup;

   logic                      pkt_valid_q, pkt_valid_next;
   logic                      pkt_error_q, pkt_error_next;
   logic                      ack_req_q, ack_req_next;
   logic                      ack_seq_q, ack_seq_next;
   pkt_type_t                 pkt_type_q, pkt_type_next;
   logic                      pkt_seq_q, pkt_seq_next;
   logic [4*DATA_BITS-1:0]    pkt_data_q, pkt_data_next;
   logic [3:0]                pkt_cnt_q, pkt_cnt_next;
   logic                      prior_seq_q, prior_seq_next;

   // Decode is done on the shift value that includes the bit sampled this cycle, so the
   // result is registered on the same edge that moves the FSM into ST_CHECK.
   always_comb begin
      hdr_shift = {hdr_sr[DATA_BITS-2:0], lanes_sync[4]};
      for (int k = 0; k < 4; k++) begin
         lane_shift[k] = {lane_sr[k][DATA_BITS-2:0], lanes_sync[k]};
      end
      frame_type = pkt_type_t'(hdr_shift[DATA_BITS-1 -: 2]);
      frame_seq  = hdr_shift[DATA_BITS-3];
      parity_ok  = ~(^{hdr_shift, lane_shift});
   end

   always_comb begin
      state_next     = state;
      bit_cnt_next   = bit_cnt;
      tmo_cnt_next   = tmo_cnt;
      hdr_sr_next    = hdr_sr;
      lane_sr_next   = lane_sr;
      pkt_valid_next = 1'b0;
      pkt_error_next = 1'b0;
      ack_req_next   = 1'b0;
      ack_seq_next   = ack_seq_q;
      pkt_type_next  = pkt_type_q;
      pkt_seq_next   = pkt_seq_q;
      pkt_data_next  = pkt_data_q;
      prior_seq_next = prior_seq_q;
      is_dup         = 1'b0;

      unique case (state)
         ST_IDLE: begin
            if (sclk_rise && lanes_sync[4]) begin
               state_next   = ST_RECV;
               bit_cnt_next = '0;
               tmo_cnt_next = TMO_LOAD;
            end
         end
         ST_RECV: begin
            if (sclk_rise) begin
               hdr_sr_next  = hdr_shift;
               lane_sr_next = lane_shift;
               tmo_cnt_next = TMO_LOAD;
               bit_cnt_next = bit_cnt + BCW'(1);
               if (bit_cnt == BIT_LAST) begin
                  state_next = ST_CHECK;
                  if (!parity_ok) begin
                     pkt_error_next = 1'b1;
                  end else begin
                     is_dup = (frame_type == PKT_DATA) && (frame_seq == prior_seq_q);
                     if (needs_ack(frame_type)) begin
                        ack_req_next = 1'b1;
                        ack_seq_next = frame_seq;
                     end
                     if (!is_dup) begin
                        pkt_valid_next = 1'b1;
                        pkt_type_next  = frame_type;
                        pkt_seq_next   = frame_seq;
                        pkt_data_next  = lane_shift;
                     end
                     if (frame_type == PKT_DATA) begin
                        prior_seq_next = frame_seq;
                     end
                  end
               end
            end else if (tmo_cnt == '0) begin
               pkt_error_next = 1'b1;
               state_next     = ST_IDLE;
            end else begin
               tmo_cnt_next = tmo_cnt - TCW'(1);
            end
         end
         ST_CHECK: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      pkt_cnt_next = pkt_cnt_q + {3'b000, pkt_valid_next};
   end

   always_ff @(posedge clk or negedge rst_sync_l) begin
      if (!rst_sync_l) begin
         state       <= ST_IDLE;
         bit_cnt     <= '0;
         tmo_cnt     <= '0;
         hdr_sr      <= '0;
         lane_sr     <= '0;
         pkt_valid_q <= 1'b0;
         pkt_error_q <= 1'b0;
         ack_req_q   <= 1'b0;
         ack_seq_q   <= 1'b0;
         pkt_type_q  <= PKT_ACK;
         pkt_seq_q   <= 1'b0;
         pkt_data_q  <= '0;
         pkt_cnt_q   <= '0;
         prior_seq_q <= 1'b1;
      end else begin
         state       <= state_next;
         bit_cnt     <= bit_cnt_next;
         tmo_cnt     <= tmo_cnt_next;
         hdr_sr      <= hdr_sr_next;
         lane_sr     <= lane_sr_next;
         pkt_valid_q <= pkt_valid_next;
         pkt_error_q <= pkt_error_next;
         ack_req_q   <= ack_req_next;
         ack_seq_q   <= ack_seq_next;
         pkt_type_q  <= pkt_type_next;
         pkt_seq_q   <= pkt_seq_next;
         pkt_data_q  <= pkt_data_next;
         pkt_cnt_q   <= pkt_cnt_next;
         prior_seq_q <= prior_seq_next;
      end
   end

   assign link.pkt_valid            = pkt_valid_q;
   assign link.pkt_error            = pkt_error_q;
   assign link.ack_req              = ack_req_q;
   assign link.ack_seqNum           = ack_seq_q;
   assign link.pkt_type             = pkt_type_q;
   assign link.pkt_seqNum           = pkt_seq_q;
   assign link.pkt_data             = pkt_data_q;
   assign link.packets_received_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_slave_link_receiver.sv
// Bench for slave_link_receiver: fixed frame table, random frames against a packet-level
// model, then timeout, counter-wrap and mid-frame-reset sequences.
module tb_slave_link_receiver;
   import slave_link_receiver_pkg::*;

   localparam int DB  = 8;
   localparam int TMO = 200;
   localparam int HP  = 20;

   logic clk   = 1'b0;
   logic rst_l = 1'b0;
   always #5 clk = ~clk;

   slave_link_receiver_if #(.DATA_BITS(DB)) link();

   slave_link_receiver #(.DATA_BITS(DB), .TIMEOUT_CYCLES(TMO)) dut (
      .clk   (clk),
      .rst_l (rst_l),
      .link  (link)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int mon_valid = 0, mon_err = 0, mon_ack = 0;
   int mon_first_cyc = -1;
   int last_rise_cyc = 0;

   always @(negedge clk) begin
      cyc++;
      if (link.pkt_valid) mon_valid++;
      if (link.pkt_error) mon_err++;
      if (link.ack_req)   mon_ack++;
      if ((link.pkt_valid || link.pkt_error || link.ack_req) && mon_first_cyc < 0)
         mon_first_cyc = cyc;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Packet-level reference: what the master expects the slave to report per frame.
   logic       m_prior;
   int         m_cnt;
   pkt_type_t  m_type;
   logic       m_seq;
   logic [31:0] m_data;
   logic       m_ack_seq;
   bit         e_valid, e_ack, e_err;

   task automatic model_reset();
      m_prior = 1'b1; m_cnt = 0; m_type = PKT_ACK; m_seq = 1'b0;
      m_data = '0; m_ack_seq = 1'b0;
   endtask

   task automatic model_frame(input pkt_type_t t, input logic s, input logic [31:0] d,
                              input bit bad);
      e_valid = 0; e_ack = 0; e_err = 0;
      if (bad) begin
         e_err = 1;
         return;
      end
      e_ack   = (t != PKT_ACK);
      e_valid = !(t == PKT_DATA && s == m_prior);
      if (t == PKT_DATA) m_prior = s;
      if (e_ack) m_ack_seq = s;
      if (e_valid) begin
         m_cnt  = (m_cnt + 1) % 16;
         m_type = t; m_seq = s; m_data = d;
      end
   endtask

   task automatic clear_mon();
      mon_valid = 0; mon_err = 0; mon_ack = 0; mon_first_cyc = -1;
   endtask

   task automatic send_frame(input pkt_type_t t, input logic s, input logic [31:0] d,
                             input bit bad, input int n_edges);
      logic [DB-1:0] hdr;
      logic          par;
      par = (^{t, s, d}) ^ bad;
      hdr = {t, s, par, 4'b0000};
      for (int e = 0; e < n_edges; e++) begin
         @(posedge clk); #1;
         if (e == 0) begin
            link.serial_in_h = 1'b1;
            {link.serial_in_3, link.serial_in_2, link.serial_in_1, link.serial_in_0} = 4'($urandom);
         end else begin
            link.serial_in_h = hdr[DB-e];
            link.serial_in_0 = d[DB-e];
            link.serial_in_1 = d[2*DB-e];
            link.serial_in_2 = d[3*DB-e];
            link.serial_in_3 = d[4*DB-e];
         end
         repeat (HP) @(posedge clk); #1;
         link.serial_clk_in = 1'b1;
         last_rise_cyc = cyc;
         repeat (HP) @(posedge clk); #1;
         link.serial_clk_in = 1'b0;
      end
      {link.serial_in_h, link.serial_in_3, link.serial_in_2, link.serial_in_1, link.serial_in_0} = '0;
   endtask

   task automatic do_frame(input pkt_type_t t, input logic s, input logic [31:0] d, input bit bad);
      clear_mon();
      send_frame(t, s, d, bad, DB + 1);
      repeat (8) @(posedge clk);
      #1;
      model_frame(t, s, d, bad);
   endtask

   task automatic check_frame(input string tag, input bit ev, input bit ea, input bit ee,
                              input logic [3:0] ecnt, input pkt_type_t etype, input logic eseq,
                              input logic [31:0] edata, input logic eack_seq);
      chk({tag, ".valid"},  mon_valid, ev ? 1 : 0);
      chk({tag, ".ack_req"}, mon_ack, ea ? 1 : 0);
      chk({tag, ".error"},  mon_err, ee ? 1 : 0);
      chk({tag, ".cnt"},    link.packets_received_cnt, ecnt);
      chk({tag, ".type"},   link.pkt_type, etype);
      chk({tag, ".seq"},    link.pkt_seqNum, eseq);
      chk({tag, ".data"},   link.pkt_data, edata);
      chk({tag, ".ack_seq"}, link.ack_seqNum, eack_seq);
      if (ev || ea || ee)
         chk({tag, ".latency_ok"}, ((mon_first_cyc - last_rise_cyc) >= 2 &&
                                    (mon_first_cyc - last_rise_cyc) <= 4), 1'b1);
   endtask

   task automatic check_model(input string tag);
      check_frame(tag, e_valid, e_ack, e_err, 4'(m_cnt), m_type, m_seq, m_data, m_ack_seq);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".valid"},   link.pkt_valid, 0);
      chk({tag, ".error"},   link.pkt_error, 0);
      chk({tag, ".ack_req"}, link.ack_req, 0);
      chk({tag, ".ack_seq"}, link.ack_seqNum, 0);
      chk({tag, ".cnt"},     link.packets_received_cnt, 0);
      chk({tag, ".type"},    link.pkt_type, PKT_ACK);
      chk({tag, ".seq"},     link.pkt_seqNum, 0);
      chk({tag, ".data"},    link.pkt_data, 0);
   endtask

   task automatic do_reset();
      #1 rst_l = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_l = 1'b1;
      repeat (5) @(posedge clk);
      model_reset();
   endtask

   typedef struct {
      pkt_type_t   t;
      logic        s;
      logic [31:0] d;
      bit          bad;
      bit          ev, ea, ee;
      logic [3:0]  ecnt;
      pkt_type_t   etype;
      logic        eseq;
      logic [31:0] edata;
      logic        eack;
   } vec_t;

   vec_t vecs[8];

   initial begin
      vecs[0] = '{PKT_DATA,      1'b0, 32'h00FF3CA5, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, PKT_DATA,      1'b0, 32'h00FF3CA5, 1'b0};
      vecs[1] = '{PKT_DATA,      1'b0, 32'h00FF3CA5, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, PKT_DATA,      1'b0, 32'h00FF3CA5, 1'b0};
      vecs[2] = '{PKT_DATA,      1'b1, 32'h12345678, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2, PKT_DATA,      1'b1, 32'h12345678, 1'b1};
      vecs[3] = '{PKT_DATA,      1'b0, 32'hCAFEBABE, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, PKT_DATA,      1'b1, 32'h12345678, 1'b1};
      vecs[4] = '{PKT_READY,     1'b1, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3, PKT_READY,     1'b1, 32'h00000000, 1'b1};
      vecs[5] = '{PKT_GAME_LOST, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 1'b0, 4'd4, PKT_GAME_LOST, 1'b0, 32'hDEADBEEF, 1'b0};
      vecs[6] = '{PKT_ACK,       1'b1, 32'h0000FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 4'd5, PKT_ACK,       1'b1, 32'h0000FFFF, 1'b0};
      vecs[7] = '{PKT_DATA,      1'b0, 32'h11223344, 1'b0, 1'b1, 1'b1, 1'b0, 4'd6, PKT_DATA,      1'b0, 32'h11223344, 1'b0};

      link.serial_clk_in = 1'b0;
      {link.serial_in_h, link.serial_in_3, link.serial_in_2, link.serial_in_1, link.serial_in_0} = '0;
      model_reset();
      repeat (4) @(posedge clk);
      #1 chk_zero("reset");
      rst_l = 1'b1;
      repeat (5) @(posedge clk);

      for (int i = 0; i < 8; i++) begin
         do_frame(vecs[i].t, vecs[i].s, vecs[i].d, vecs[i].bad);
         check_frame($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ea, vecs[i].ee, vecs[i].ecnt,
                     vecs[i].etype, vecs[i].eseq, vecs[i].edata, vecs[i].eack);
      end

      // Serial clock stops after four data edges.
      clear_mon();
      send_frame(PKT_DATA, 1'b1, 32'h0F0F0F0F, 1'b0, 5);
      repeat (TMO - 10 - (cyc - last_rise_cyc)) @(posedge clk);
      #1 chk("timeout.early", mon_err, 0);
      for (int i = 0; i < 40 && mon_err == 0; i++) @(posedge clk);
      #1;
      chk("timeout.error", mon_err, 1);
      chk("timeout.valid", mon_valid, 0);
      chk("timeout.ack", mon_ack, 0);
      do_frame(PKT_READY, 1'b0, 32'($urandom), 1'b0);
      check_model("after_timeout");

      for (int i = 0; i < 12; i++) begin
         pkt_type_t rt;
         rt = pkt_type_t'($urandom_range(0, 3));
         do_frame(rt, 1'($urandom_range(0, 1)), 32'($urandom), ($urandom_range(0, 4) == 0));
         check_model($sformatf("rand%0d", i));
      end

      do_reset();
      for (int i = 0; i < 17; i++) begin
         pkt_type_t wt;
         logic      ws;
         wt = (i == 5) ? PKT_ACK : PKT_DATA;
         ws = (wt == PKT_DATA) ? ~m_prior : 1'($urandom_range(0, 1));
         do_frame(wt, ws, 32'($urandom), 1'b0);
         check_model($sformatf("wrap%0d", i));
      end
      chk("wrap.cnt", link.packets_received_cnt, 4'd1);

      clear_mon();
      send_frame(PKT_DATA, 1'b0, 32'h5A5A1234, 1'b0, 6);
      rst_l = 1'b0;
      #1 chk_zero("midreset");
      repeat (3) @(posedge clk);
      #1 rst_l = 1'b1;
      clear_mon();
      repeat (20) @(posedge clk);
      #1;
      chk("midreset.no_pulse", mon_valid + mon_err + mon_ack, 0);
      model_reset();
      do_frame(PKT_DATA, 1'b0, 32'hA1B2C3D4, 1'b0);
      check_model("after_midreset");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
